// File: rtl/c64_mem_pkg.sv
// Shared types and port identifiers for the c64 SDRAM request path.
package c64_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic [1:0] PORT_CORE  = 2'd0;
  localparam logic [1:0] PORT_DRIVE = 2'd1;
  localparam logic [1:0] PORT_IOCTL = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of the SDRAM controller: core has fixed priority,
// drive/ioctl share round-robin with a starvation override.
module sdram_port_arbiter
  import c64_mem_pkg::*;
#(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   din,
  input  logic [5:0]            be,
  output logic [2:0]            ack,
  output logic [3*DATA_W-1:0]   dout,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  output logic [1:0]            mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_done,
  input  logic [DATA_W-1:0]     mem_dout
);

  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t              state_reg, state_next;
  logic [1:0]              grant_reg, grant_next;
  logic [1:0]              rr_reg, rr_next;
  logic [CNT_W-1:0]        starve_reg, starve_next;
  logic                    mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]       mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]       mem_din_reg, mem_din_next;
  logic [1:0]              mem_be_reg, mem_be_next;
  logic [3*DATA_W-1:0]     dout_reg, dout_next;
  logic [1:0]              sel_port;

  // Low port prefers rr; it only beats the core once the core has starved it.
  function automatic logic [1:0] select_port(input logic [2:0] r, input logic [1:0] rr,
                                             input logic [CNT_W-1:0] cnt);
    logic [1:0] low;
    low = GRANT_NONE;
    if (rr == PORT_IOCTL) begin
      if (r[2])      low = PORT_IOCTL;
      else if (r[1]) low = PORT_DRIVE;
    end else begin
      if (r[1])      low = PORT_DRIVE;
      else if (r[2]) low = PORT_IOCTL;
    end
    if (low != GRANT_NONE && cnt == STARVE_LIM) return low;
    else if (r[0])                              return PORT_CORE;
    else                                        return low;
  endfunction

  assign sel_port = select_port(req, rr_reg, starve_reg);

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_next       = rr_reg;
    starve_next   = starve_reg;
    mem_we_next   = mem_we_reg;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;
    mem_be_next   = mem_be_reg;
    dout_next     = dout_reg;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = ISSUE;
          grant_next = sel_port;
          for (int p = 0; p < 3; p++) begin
            if (sel_port == 2'(p)) begin
              mem_we_next   = we[p];
              mem_addr_next = addr[p*ADDR_W +: ADDR_W];
              mem_din_next  = din[p*DATA_W +: DATA_W];
              mem_be_next   = be[p*2 +: 2];
            end
          end
          if (sel_port == PORT_CORE) begin
            if ((req[1] | req[2]) && starve_reg != STARVE_LIM)
              starve_next = starve_reg + 1'b1;
          end else begin
            starve_next = '0;
            rr_next     = (sel_port == PORT_DRIVE) ? PORT_IOCTL : PORT_DRIVE;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          state_next = ACK;
          if (!mem_we_reg) begin
            for (int p = 0; p < 3; p++) begin
              if (grant_reg == 2'(p)) dout_next[p*DATA_W +: DATA_W] = mem_dout;
            end
          end
        end
      end
      ACK: begin
        state_next = IDLE;
        grant_next = GRANT_NONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      grant_reg    <= GRANT_NONE;
      rr_reg       <= PORT_DRIVE;
      starve_reg   <= '0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      mem_be_reg   <= '0;
      dout_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_reg       <= rr_next;
      starve_reg   <= starve_next;
      mem_we_reg   <= mem_we_next;
      mem_addr_reg <= mem_addr_next;
      mem_din_reg  <= mem_din_next;
      mem_be_reg   <= mem_be_next;
      dout_reg     <= dout_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ack
      assign ack[gi] = (state_reg == ACK) && (grant_reg == 2'(gi));
    end
  endgenerate

  assign dout     = dout_reg;
  assign grant_id = grant_reg;
  assign busy     = (state_reg != IDLE);
  assign mem_req  = (state_reg == ISSUE);
  assign mem_we   = mem_we_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;
  assign mem_be   = mem_be_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomised self-checking bench for sdram_port_arbiter with a transaction-level arbitration model.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  logic                clk_sys = 1'b0;
  logic                reset_n = 1'b0;
  logic [2:0]          req = '0;
  logic [2:0]          we = '0;
  logic [3*ADDR_W-1:0] addr = '0;
  logic [3*DATA_W-1:0] din = '0;
  logic [5:0]          be = '0;
  logic [2:0]          ack;
  logic [3*DATA_W-1:0] dout;
  logic [1:0]          grant_id;
  logic                busy;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_din;
  logic [1:0]          mem_be;
  logic                mem_ready = 1'b0;
  logic                mem_done = 1'b0;
  logic [DATA_W-1:0]   mem_dout = '0;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .din(din), .be(be),
    .ack(ack), .dout(dout), .grant_id(grant_id), .busy(busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_dout(mem_dout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Requester attribute tables driven onto the per-port buses.
  logic              t_we[3];
  logic [ADDR_W-1:0] t_addr[3];
  logic [DATA_W-1:0] t_din[3];
  logic [1:0]        t_be[3];

  // Reference model: arbitration rules at transaction level plus expected dout.
  int                m_rr;
  int                m_starve;
  logic [DATA_W-1:0] m_dout[3];

  function automatic int model_grant(input logic [2:0] r);
    int low;
    int g;
    low = 3;
    if (m_rr == 2) begin
      if (r[2]) low = 2; else if (r[1]) low = 1;
    end else begin
      if (r[1]) low = 1; else if (r[2]) low = 2;
    end
    if (low != 3 && m_starve == 8) g = low;
    else if (r[0])                 g = 0;
    else                           g = low;
    if (g == 0) begin
      if (low != 3 && m_starve < 8) m_starve = m_starve + 1;
    end else begin
      m_starve = 0;
      m_rr = (g == 1) ? 2 : 1;
    end
    return g;
  endfunction

  task automatic model_reset();
    m_rr = 1;
    m_starve = 0;
    for (int p = 0; p < 3; p++) m_dout[p] = '0;
  endtask

  task automatic randomize_attrs();
    for (int p = 0; p < 3; p++) begin
      t_we[p]   = 1'($urandom_range(0, 1));
      t_addr[p] = ADDR_W'($urandom);
      t_din[p]  = DATA_W'($urandom);
      t_be[p]   = 2'($urandom);
    end
  endtask

  task automatic apply_attrs();
    for (int p = 0; p < 3; p++) begin
      we[p]                   = t_we[p];
      addr[p*ADDR_W +: ADDR_W] = t_addr[p];
      din[p*DATA_W +: DATA_W]  = t_din[p];
      be[p*2 +: 2]             = t_be[p];
    end
  endtask

  // No DUT activity expected anywhere may produce more than one ack.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      n_cmp++;
      if ($countones(ack) > 1) begin
        n_bad++;
        $display("FAIL ack_onehot: ack=%b required at most one bit", ack);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0; req = '0; mem_ready = 1'b0; mem_done = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One full access; caller sits at a negedge with the arbiter idle.
  task automatic do_txn(input logic [2:0] r, input int rdy_dly, input int done_dly,
                        input logic [DATA_W-1:0] rdata, output int obs_g, output int grant_cyc);
    int                exp_g;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din;
    logic [1:0]        e_be;
    int                waited;
    obs_g = 3;
    grant_cyc = 0;
    apply_attrs();
    req = r;
    exp_g  = model_grant(r);
    e_we   = t_we[exp_g];
    e_addr = t_addr[exp_g];
    e_din  = t_din[exp_g];
    e_be   = t_be[exp_g];
    @(negedge clk_sys);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL grant_latency: mem_req=%b required 1 one cycle after req", mem_req);
      waited = 0;
      while (mem_req !== 1'b1 && waited < 8) begin
        @(negedge clk_sys);
        waited++;
      end
      if (mem_req !== 1'b1) begin
        n_bad++;
        $display("FAIL grant_timeout: no mem_req within 8 cycles");
        req = '0;
        return;
      end
    end
    grant_cyc = cyc;
    obs_g = int'(grant_id);
    n_cmp++;
    if (grant_id !== 2'(exp_g)) begin
      n_bad++; $display("FAIL grant_port: grant_id=%0d required %0d (req=%b)", grant_id, exp_g, r);
    end
    n_cmp++;
    if ({mem_we, mem_addr, mem_din, mem_be} !== {e_we, e_addr, e_din, e_be}) begin
      n_bad++;
      $display("FAIL latch: we=%b addr=%h din=%h be=%b required we=%b addr=%h din=%h be=%b",
               mem_we, mem_addr, mem_din, mem_be, e_we, e_addr, e_din, e_be);
    end
    // Change everything after grant; the in-flight access must not notice.
    randomize_attrs();
    apply_attrs();
    req[exp_g] = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk_sys);
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_din, mem_be} !== {1'b1, e_we, e_addr, e_din, e_be}) begin
        n_bad++;
        $display("FAIL issue_hold: req=%b we=%b addr=%h din=%h be=%b required req=1 we=%b addr=%h din=%h be=%b",
                 mem_req, mem_we, mem_addr, mem_din, mem_be, e_we, e_addr, e_din, e_be);
      end
    end
    mem_ready = 1'b1;
    @(negedge clk_sys);
    mem_ready = 1'b0;
    n_cmp++;
    if ({mem_req, busy, grant_id} !== {1'b0, 1'b1, 2'(exp_g)}) begin
      n_bad++;
      $display("FAIL wait_state: mem_req=%b busy=%b grant_id=%0d required 0 1 %0d",
               mem_req, busy, grant_id, exp_g);
    end
    for (int i = 0; i < done_dly; i++) @(negedge clk_sys);
    mem_done = 1'b1;
    mem_dout = rdata;
    @(negedge clk_sys);
    mem_done = 1'b0;
    mem_dout = DATA_W'($urandom);
    if (!e_we) m_dout[exp_g] = rdata;
    n_cmp++;
    if (ack !== 3'(1 << exp_g)) begin
      n_bad++; $display("FAIL ack_pulse: ack=%b required %b", ack, 3'(1 << exp_g));
    end
    for (int p = 0; p < 3; p++) begin
      n_cmp++;
      if (dout[p*DATA_W +: DATA_W] !== m_dout[p]) begin
        n_bad++;
        $display("FAIL dout%0d: dout=%h required %h", p, dout[p*DATA_W +: DATA_W], m_dout[p]);
      end
    end
    @(negedge clk_sys);
    n_cmp++;
    if ({ack, grant_id, busy, mem_req} !== {3'b000, 2'd3, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL post_ack: ack=%b grant_id=%0d busy=%b mem_req=%b required 000 3 0 0",
               ack, grant_id, busy, mem_req);
    end
    req = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({grant_id, busy, mem_req, ack} !== {2'd3, 1'b0, 1'b0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_ctrl: grant_id=%0d busy=%b mem_req=%b ack=%b required 3 0 0 000",
               grant_id, busy, mem_req, ack);
    end
    n_cmp++;
    if ({dout, mem_we, mem_addr, mem_din, mem_be} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: dout=%h we=%b addr=%h din=%h be=%b required all zero",
               dout, mem_we, mem_addr, mem_din, mem_be);
    end
  endtask

  task automatic test_single_read();
    int g, gc;
    randomize_attrs();
    t_we[1] = 1'b0;
    t_addr[1] = 25'h0001234;
    do_txn(3'b010, 0, 1, 16'hBEEF, g, gc);
    n_cmp++;
    if (dout[DATA_W +: DATA_W] !== 16'hBEEF) begin
      n_bad++; $display("FAIL single_read: dout[1]=%h required beef", dout[DATA_W +: DATA_W]);
    end
    $display("single_read: port=%0d dout1=%h", g, dout[DATA_W +: DATA_W]);
  endtask

  task automatic test_starvation();
    int g, gc, exp_g;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      randomize_attrs();
      do_txn(3'b111, 0, 0, DATA_W'($urandom), g, gc);
      exp_g = (i == 8) ? 1 : ((i == 17) ? 2 : 0);
      n_cmp++;
      if (g !== exp_g) begin
        n_bad++; $display("FAIL starve_order: grant %0d port=%0d required %0d", i, g, exp_g);
      end
      $display("starvation: grant %0d port=%0d", i, g);
    end
  endtask

  task automatic test_back_to_back();
    int g, gc, prev_gc;
    do_reset();
    prev_gc = 0;
    for (int i = 0; i < 6; i++) begin
      randomize_attrs();
      do_txn(3'b110, 0, 0, DATA_W'($urandom), g, gc);
      n_cmp++;
      if (g !== ((i % 2 == 0) ? 1 : 2)) begin
        n_bad++; $display("FAIL rr_order: grant %0d port=%0d required %0d", i, g, (i % 2 == 0) ? 1 : 2);
      end
      if (i > 0) begin
        n_cmp++;
        if (gc - prev_gc !== 4) begin
          n_bad++; $display("FAIL rr_spacing: spacing=%0d required 4", gc - prev_gc);
        end
      end
      $display("back_to_back: grant %0d port=%0d cycle=%0d", i, g, gc);
      prev_gc = gc;
    end
  endtask

  task automatic test_write_stall();
    int g, gc;
    randomize_attrs();
    t_we[2] = 1'b0;
    do_txn(3'b100, 0, 0, 16'h1357, g, gc);
    randomize_attrs();
    t_we[2] = 1'b1;
    t_din[2] = 16'h55AA;
    t_be[2] = 2'b01;
    do_txn(3'b100, 5, 0, 16'hDEAD, g, gc);
    n_cmp++;
    if (dout[2*DATA_W +: DATA_W] !== 16'h1357) begin
      n_bad++; $display("FAIL write_dout: dout[2]=%h required 1357", dout[2*DATA_W +: DATA_W]);
    end
    $display("write_stall: port=%0d dout2=%h", g, dout[2*DATA_W +: DATA_W]);
  endtask

  task automatic test_reset_mid_access();
    int g, gc;
    randomize_attrs();
    apply_attrs();
    req = 3'b010;
    g = model_grant(3'b010);
    @(negedge clk_sys);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++; $display("FAIL midrst_grant: mem_req=%b required 1", mem_req);
    end
    mem_ready = 1'b1;
    @(negedge clk_sys);
    mem_ready = 1'b0;
    reset_n = 1'b0;
    req = '0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    mem_done = 1'b1;
    mem_dout = 16'hFFFF;
    model_reset();
    n_cmp++;
    if ({grant_id, busy, mem_req, ack, dout, mem_addr} !== {2'd3, 1'b0, 1'b0, 3'b000, {3*DATA_W{1'b0}}, {ADDR_W{1'b0}}}) begin
      n_bad++;
      $display("FAIL midrst_state: grant_id=%0d busy=%b mem_req=%b ack=%b dout=%h addr=%h required reset values",
               grant_id, busy, mem_req, ack, dout, mem_addr);
    end
    @(negedge clk_sys);
    mem_done = 1'b0;
    n_cmp++;
    if ({ack, busy} !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_noack: ack=%b busy=%b required 000 0", ack, busy);
    end
    randomize_attrs();
    do_txn(3'b010, 1, 1, 16'hA5C3, g, gc);
    $display("reset_mid_access: recovered port=%0d dout1=%h", g, dout[DATA_W +: DATA_W]);
  endtask

  task automatic test_random();
    int g, gc;
    logic [2:0] r;
    for (int i = 0; i < 40; i++) begin
      r = 3'($urandom_range(1, 7));
      randomize_attrs();
      do_txn(r, $urandom_range(0, 3), $urandom_range(0, 3), DATA_W'($urandom), g, gc);
      $display("random: txn %0d req=%b port=%0d", i, r, g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    randomize_attrs();
    test_reset();
    test_single_read();
    test_starvation();
    test_back_to_back();
    test_write_stall();
    test_reset_mid_access();
    test_random();
    @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
